// File: rtl/adder_arbiter.sv
// ============================================================================
// adder_arbiter : two-requester round-robin arbiter feeding a registered adder
// Rev 1.0
// ============================================================================
`default_nettype none

module adder_arbiter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_i,
  input  logic             v0_i,
  input  logic [WIDTH-1:0] a0_i,
  input  logic [WIDTH-1:0] b0_i,
  output logic             ready0_o,
  input  logic             v1_i,
  input  logic [WIDTH-1:0] a1_i,
  input  logic [WIDTH-1:0] b1_i,
  output logic             ready1_o,
  output logic             v_o,
  output logic [WIDTH:0]   sum_o,
  output logic             is_odd_o,
  output logic             id_o,
  input  logic             ready_i,
  output logic [CNT_W-1:0] done_cnt_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             op_id_q, op_id_d;
  logic             last_q, last_d;
  logic [WIDTH:0]   sum_q, sum_d;
  logic             id_q, id_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic can_accept;
  logic accept;
  logic gnt;

  // On a tie the requester that did not win last time is served.
  always_comb begin
    can_accept = (state_q == IDLE) || ((state_q == DONE) && ready_i);
    accept     = can_accept && (v0_i || v1_i) && !reset_i;
    gnt        = (v0_i && v1_i) ? ~last_q : v1_i;
    ready0_o   = accept && !gnt;
    ready1_o   = accept && gnt;
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_id_d = op_id_q;
    last_d  = last_q;
    sum_d   = sum_q;
    id_d    = id_q;
    cnt_d   = cnt_q;

    if (accept) begin
      a_d     = gnt ? a1_i : a0_i;
      b_d     = gnt ? b1_i : b0_i;
      op_id_d = gnt;
      last_d  = gnt;
    end

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = CALC;
        end
      end
      CALC: begin
        sum_d   = {1'b0, a_q} + {1'b0, b_q};
        id_d    = op_id_q;
        state_d = DONE;
      end
      DONE: begin
        if (ready_i) begin
          cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          state_d = accept ? CALC : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_id_q <= 1'b0;
      last_q  <= 1'b1;
      sum_q   <= '0;
      id_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_id_q <= op_id_d;
      last_q  <= last_d;
      sum_q   <= sum_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
    end
  end

  assign v_o        = (state_q == DONE);
  assign sum_o      = sum_q;
  assign is_odd_o   = sum_q[0];
  assign id_o       = id_q;
  assign done_cnt_o = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_adder_arbiter.sv
// ============================================================================
// tb_adder_arbiter : directed stimulus, transaction-level model, per-cycle compare
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_adder_arbiter;

  localparam int WIDTH = 8;
  localparam int CNT_W = 2;
  localparam int CNT_MOD = 1 << CNT_W;

  logic             clk;
  logic             reset_i;
  logic             v0_i, v1_i;
  logic [WIDTH-1:0] a0_i, b0_i, a1_i, b1_i;
  logic             ready0_o, ready1_o;
  logic             v_o;
  logic [WIDTH:0]   sum_o;
  logic             is_odd_o;
  logic             id_o;
  logic             ready_i;
  logic [CNT_W-1:0] done_cnt_o;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  adder_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset_i   (reset_i),
    .v0_i      (v0_i),
    .a0_i      (a0_i),
    .b0_i      (b0_i),
    .ready0_o  (ready0_o),
    .v1_i      (v1_i),
    .a1_i      (a1_i),
    .b1_i      (b1_i),
    .ready1_o  (ready1_o),
    .v_o       (v_o),
    .sum_o     (sum_o),
    .is_odd_o  (is_odd_o),
    .id_o      (id_o),
    .ready_i   (ready_i),
    .done_cnt_o(done_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Transaction model: an accepted op is "in flight" for one cycle, then its
  // result is presented until consumed.
  bit m_ok = 0;
  bit m_in_flight, m_res_valid, m_id, m_last, m_pid;
  int m_sum, m_cnt, m_pa, m_pb;

  function automatic bit m_accept();
    bit free;
    free = !m_in_flight && (!m_res_valid || ready_i);
    return free && (v0_i || v1_i) && !reset_i;
  endfunction

  function automatic bit m_winner();
    if (v0_i && v1_i) return (m_last == 1'b1) ? 1'b0 : 1'b1;
    return v1_i ? 1'b1 : 1'b0;
  endfunction

  always @(posedge clk) begin
    bit acc, win;
    if (reset_i) begin
      m_ok = 1; m_in_flight = 0; m_res_valid = 0;
      m_sum = 0; m_id = 0; m_cnt = 0; m_last = 1;
    end else begin
      acc = m_accept();
      win = m_winner();
      if (m_res_valid && ready_i) begin
        m_cnt = (m_cnt + 1) % CNT_MOD;
        m_res_valid = 0;
      end
      if (m_in_flight) begin
        m_sum = m_pa + m_pb;
        m_id = m_pid;
        m_res_valid = 1;
        m_in_flight = 0;
      end
      if (acc) begin
        m_in_flight = 1;
        m_pa  = win ? int'(a1_i) : int'(a0_i);
        m_pb  = win ? int'(b1_i) : int'(b0_i);
        m_pid = win;
        m_last = win;
      end
    end
  end

  always @(negedge clk) begin
    bit acc, win;
    if (m_ok) begin
      acc = m_accept();
      win = m_winner();
      chk("ready0", ready0_o, acc && !win);
      chk("ready1", ready1_o, acc && win);
      chk("v_o", v_o, m_res_valid);
      chk("sum_o", sum_o, m_sum);
      chk("is_odd_o", is_odd_o, m_sum % 2);
      chk("id_o", id_o, m_id);
      chk("done_cnt", done_cnt_o, m_cnt);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_v();
    bit ok;
    ok = 0;
    for (int i = 0; i < 8; i++) begin
      if (v_o) begin ok = 1; break; end
      step();
    end
    if (!ok) chk("v_o_timeout", 0, 1);
  endtask

  task automatic do_op(input bit req, input int a, input int b,
                       output int s, output int odd, output int id);
    if (req) begin v1_i = 1; a1_i = WIDTH'(a); b1_i = WIDTH'(b); end
    else     begin v0_i = 1; a0_i = WIDTH'(a); b0_i = WIDTH'(b); end
    ready_i = 1;
    step();
    v0_i = 0; v1_i = 0;
    wait_v();
    s = int'(sum_o); odd = int'(is_odd_o); id = int'(id_o);
    step();
  endtask

  task automatic drain();
    v0_i = 0; v1_i = 0; ready_i = 1;
    repeat (4) step();
  endtask

  initial begin
    int s, o, id, prev;
    int exp_cnt [5];
    exp_cnt = '{1, 2, 3, 0, 1};

    reset_i = 1; v0_i = 1; v1_i = 1; ready_i = 0;
    a0_i = 0; b0_i = 0; a1_i = 0; b1_i = 0;
    step(); step();
    chk("rst_ready0", ready0_o, 0);
    chk("rst_ready1", ready1_o, 0);
    chk("rst_v", v_o, 0);
    chk("rst_sum", sum_o, 0);
    chk("rst_id", id_o, 0);
    chk("rst_cnt", done_cnt_o, 0);
    reset_i = 0; v0_i = 0; v1_i = 0;
    step();

    // Tie with both held: alternating owners, one result every two cycles
    a0_i = 2; b0_i = 2; a1_i = 9; b1_i = 10;
    v0_i = 1; v1_i = 1; ready_i = 1;
    #1;
    chk("tie_first_ready0", ready0_o, 1);
    prev = 0;
    for (int k = 0; k < 4; k++) begin
      wait_v();
      chk("tie_id", id_o, k % 2);
      chk("tie_sum", sum_o, (k % 2) ? 19 : 4);
      chk("tie_odd", is_odd_o, k % 2);
      if (k > 0) chk("tie_gap", cyc - prev, 2);
      prev = cyc;
      step();
    end
    drain();

    // Single op
    do_op(0, 0, 1, s, o, id);
    chk("single_sum", s, 1);
    chk("single_odd", o, 1);
    chk("single_id", id, 0);
    drain();

    // Backpressure: result must hold while a competing request waits
    ready_i = 0; v0_i = 1; a0_i = 15; b0_i = 5;
    step();
    v0_i = 0; v1_i = 1; a1_i = 3; b1_i = 3;
    wait_v();
    for (int i = 0; i < 5; i++) begin
      chk("bp_v", v_o, 1);
      chk("bp_sum", sum_o, 20);
      chk("bp_id", id_o, 0);
      chk("bp_no_accept", ready1_o, 0);
      step();
    end
    v1_i = 0; ready_i = 1;
    step();
    chk("bp_released", v_o, 0);
    drain();

    // Width boundary
    do_op(0, 255, 255, s, o, id);
    chk("w_sum_510", s, 510);
    chk("w_odd_510", o, 0);
    do_op(1, 255, 0, s, o, id);
    chk("w_sum_255", s, 255);
    chk("w_odd_255", o, 1);
    chk("w_id_255", id, 1);
    drain();

    // Reset during CALC discards the op and restores tie priority to requester 0
    v0_i = 1; a0_i = 4; b0_i = 7; ready_i = 1;
    step();
    v0_i = 0; reset_i = 1;
    step();
    reset_i = 0;
    chk("rmid_v", v_o, 0);
    chk("rmid_cnt", done_cnt_o, 0);
    step();
    chk("rmid_v_later", v_o, 0);
    v0_i = 1; v1_i = 1;
    #1;
    chk("rmid_tie_r0", ready0_o, 1);
    chk("rmid_tie_r1", ready1_o, 0);
    step();
    drain();

    // Counter wrap with a 2-bit counter
    reset_i = 1;
    step();
    reset_i = 0;
    for (int i = 0; i < 5; i++) begin
      do_op(i % 2, i, i + 3, s, o, id);
      chk("wrap_sum", s, 2 * i + 3);
      chk("wrap_cnt", done_cnt_o, exp_cnt[i]);
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
